voice_allocator: RTL
====================

// Module: voice_allocator
// PURPOSE
//  Schedules MIDI note events onto the VOICES synth voices. Accepts one note-on/off event at a time and picks the target voice:
//  key retrigger, else lowest free voice, else steal the oldest. Drives the synth engine note interface
//  (keys_on, note_on, cur_key_adr/val, cur_vel_on/off) and holds note_on for a full voice-scan frame.
// PARAMETERS
//  VOICES       8    number of voices
//  V_WIDTH      3    log2(VOICES)
//  HOLD_CYCLES  256  OSC_CLK cycles note_on stays high; must be >= one full xxxx frame of the engine
// PORTS
//  OSC_CLK       in   1        clock; all logic on posedge
//  reset_reg_N   in   1        asynchronous, active-low reset
//  ev_valid      in   1        note event present
//  ev_ready      out  1        allocator can accept an event
//  ev_is_on      in   1        1 = note-on, 0 = note-off
//  ev_key        in   8        MIDI key number
//  ev_vel        in   8        velocity (on or off, per ev_is_on)
//  all_notes_off in   1        level/pulse: release every voice
//  voice_free    in   VOICES   from env gen: voice envelope finished
//  keys_on       out  VOICES   gate per voice
//  note_on       out  1        new-note strobe, held HOLD_CYCLES
//  cur_key_adr   out  V_WIDTH  voice index of last allocation
//  cur_key_val   out  8        key of last allocation
//  cur_vel_on    out  8        on-velocity of last note-on
//  cur_vel_off   out  8        off-velocity of last note-off
// BEHAVIOUR
//  Reset (async): keys_on=0, note_on=0, cur_*=0, stored keys=0, age rank[i]=i, state IDLE, ev_ready=1 once released.
//  ev_ready = (state==IDLE) && !aon_pend. Event accepted on posedge with ev_valid&ev_ready; ev_* latched then.
//  FSM: IDLE -> SCAN (VOICES cycles, one voice per cycle, index 0..VOICES-1) -> COMMIT (1 cycle)
//       -> HOLD (note-on only, HOLD_CYCLES cycles) -> IDLE. Note-off: COMMIT -> IDLE.
//  Scan per voice i: match = (key[i]==ev_key) && (keys_on[i] || !voice_free[i]);
//       free = voice_free[i] && !keys_on[i]; oldest = rank[i]==VOICES-1. First index wins within each class.
//  Note-on choice: first match, else first free, else oldest (steal). At COMMIT edge: keys_on[v]=1, key[v]=ev_key,
//       cur_key_adr=v, cur_key_val=ev_key, cur_vel_on=ev_vel, note_on=1; rank: voices with rank<rank[v] +1, rank[v]=0.
//  Note-off: match restricted to keys_on[i]=1. Hit: keys_on[v]=0, cur_vel_off=ev_vel, rank unchanged, no note_on.
//       Miss: event consumed, no output change.
//  Latency: accept at edge T, outputs update at edge T+VOICES+1, note_on falls at T+VOICES+1+HOLD_CYCLES,
//       ev_ready high again the cycle after.
//  all_notes_off: in IDLE clears keys_on next edge and blocks ev_ready that cycle (wins over simultaneous ev_valid);
//       when busy, latched in aon_pend and applied on return to IDLE, before next event; note_on not affected.
//  Rank values remain a permutation of 0..VOICES-1 at all times; no wrap.
//  voice_free sampled live during SCAN; changes mid-scan only affect later indices.
//  Reset mid-operation: abort immediately to reset values; a latched event is discarded.
// STRUCTURE
//  voice_alloc_defs.vh: FSM state encoding (IDLE/SCAN/COMMIT/HOLD), hold-counter width, class priority encoding.
//  Sub-module voice_age_tracker: rank array, oldest-index lookup, promote-to-0 update; instantiated once.
//  Top: FSM, scan counter, candidate registers (match/free/oldest found + index), hold counter, key store.
// TESTING
//  1 Reset, voice_free=all 1, note-on key 60 vel 100 -> voice 0, keys_on=01h, note_on high HOLD_CYCLES, cur_key_val=60.
//  2 Note-on 60,62,64 then note-off 62 vel 40 -> keys_on 07h->05h, cur_vel_off=40, no note_on pulse.
//  3 Note-on key 60 while voice 0 already holds 60 -> retrigger voice 0, keys_on unchanged, note_on pulses.
//  4 Fill 8 voices (keys 60..67, voice_free=0) then key 70 -> steals voice 0 (oldest); next steal voice 1.
//  5 Note-off key 99 not held -> accepted, ev_ready back after VOICES+2 cycles, all outputs unchanged.
//  6 all_notes_off during HOLD -> keys_on stays until HOLD ends, then 0; queued ev_valid accepted only after.

Source files
------------

// File: rtl/voice_allocator_pkg.sv
// Shared types for the voice allocator: FSM states, candidate classes,
// default sizing and the class priority encoder.
package voice_allocator_pkg;

    localparam int VOICES_DEF      = 8;
    localparam int V_WIDTH_DEF     = 3;
    localparam int HOLD_CYCLES_DEF = 256;
    localparam int HOLD_W_DEF      = $clog2(HOLD_CYCLES_DEF) + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_COMMIT,
        ST_HOLD
    } va_state_t;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_MATCH,
        CLS_FREE,
        CLS_OLDEST
    } va_class_t;

    // Retrigger beats a free voice, which beats stealing.
    function automatic va_class_t pick_class(
        input logic match_f,
        input logic free_f,
        input logic old_f
    );
        if (match_f)     return CLS_MATCH;
        else if (free_f) return CLS_FREE;
        else if (old_f)  return CLS_OLDEST;
        else             return CLS_NONE;
    endfunction

endpackage

// File: rtl/voice_allocator_if.sv
// Note-event handshake bundle (valid/ready plus event payload).
// master drives the event, slave (the allocator) drives ev_ready.
interface voice_allocator_if;

    logic       ev_valid;
    logic       ev_ready;
    logic       ev_is_on;
    logic [7:0] ev_key;
    logic [7:0] ev_vel;

    modport master (
        output ev_valid,
        output ev_is_on,
        output ev_key,
        output ev_vel,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_is_on,
        input  ev_key,
        input  ev_vel,
        output ev_ready
    );

endinterface

// File: rtl/voice_age_tracker.sv
// Voice age ranks: 0 = newest, VOICES-1 = oldest (steal candidate).
// Ports: OSC_CLK, reset_reg_N, promote/promote_idx in, is_oldest out.
module voice_age_tracker #(
    parameter int VOICES  = 8,
    parameter int V_WIDTH = 3
) (
    input  logic               OSC_CLK,
    input  logic               reset_reg_N,
    input  logic               promote,
    input  logic [V_WIDTH-1:0] promote_idx,
    output logic [VOICES-1:0]  is_oldest
);

    logic [V_WIDTH-1:0] rank [VOICES];

    // Everything younger than the promoted voice ages by one, so the
    // ranks stay a permutation without ever wrapping.
    always_ff @(posedge OSC_CLK or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            for (int i = 0; i < VOICES; i++) begin
                rank[i] <= V_WIDTH'(i);
            end
        end else if (promote) begin
            for (int i = 0; i < VOICES; i++) begin
                if (V_WIDTH'(i) == promote_idx) begin
                    rank[i] <= '0;
                end else if (rank[i] < rank[promote_idx]) begin
                    rank[i] <= rank[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        is_oldest = '0;
        for (int i = 0; i < VOICES; i++) begin
            is_oldest[i] = (rank[i] == V_WIDTH'(VOICES - 1));
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Note event to synth voice allocator: retrigger, lowest free, or steal.
// Ports: OSC_CLK, reset_reg_N, ev_bus (slave), all_notes_off, voice_free,
// keys_on, note_on, cur_key_adr, cur_key_val, cur_vel_on, cur_vel_off.
module voice_allocator
    import voice_allocator_pkg::*;
#(
    parameter int VOICES      = VOICES_DEF,
    parameter int V_WIDTH     = V_WIDTH_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic                OSC_CLK,
    input  logic                reset_reg_N,
    voice_allocator_if.slave    ev_bus,
    input  logic                all_notes_off,
    input  logic [VOICES-1:0]   voice_free,
    output logic [VOICES-1:0]   keys_on,
    output logic                note_on,
    output logic [V_WIDTH-1:0]  cur_key_adr,
    output logic [7:0]          cur_key_val,
    output logic [7:0]          cur_vel_on,
    output logic [7:0]          cur_vel_off
);

    localparam int HW = $clog2(HOLD_CYCLES) + 1;

    va_state_t          state;
    va_state_t          state_nxt;
    logic [V_WIDTH-1:0] scan_idx;
    logic [HW-1:0]      hold_cnt;
    logic               aon_pend;

    logic               lat_on;
    logic [7:0]         lat_key;
    logic [7:0]         lat_vel;
    logic [7:0]         key_mem [VOICES];

    logic               match_f;
    logic               free_f;
    logic               old_f;
    logic [V_WIDTH-1:0] match_idx;
    logic [V_WIDTH-1:0] free_idx;
    logic [V_WIDTH-1:0] old_idx;

    logic               accept;
    logic               last_scan;
    logic               hold_done;
    logic               aon_now;
    logic               is_match;
    logic               is_free;
    logic               is_old;
    logic [VOICES-1:0]  is_oldest;
    va_class_t          sel_cls;
    logic [V_WIDTH-1:0] sel_idx;
    logic               promote;

    assign aon_now = all_notes_off || aon_pend;

    // A pending or fresh all-notes-off takes the IDLE cycle for itself.
    assign ev_bus.ev_ready = (state == ST_IDLE) && !aon_now;
    assign accept          = ev_bus.ev_valid && ev_bus.ev_ready;
    assign last_scan       = scan_idx == V_WIDTH'(VOICES - 1);
    assign hold_done       = hold_cnt == HW'(HOLD_CYCLES - 1);

    // Classify the voice under the scan pointer; voice_free is live.
    always_comb begin
        is_match = key_mem[scan_idx] == lat_key;
        if (lat_on) begin
            is_match = is_match &&
                (keys_on[scan_idx] || !voice_free[scan_idx]);
        end else begin
            is_match = is_match && keys_on[scan_idx];
        end
        is_free = voice_free[scan_idx] && !keys_on[scan_idx];
        is_old  = is_oldest[scan_idx];
    end

    always_comb begin
        sel_cls = pick_class(match_f, free_f, old_f);
        sel_idx = old_idx;
        unique case (sel_cls)
            CLS_MATCH: sel_idx = match_idx;
            CLS_FREE:  sel_idx = free_idx;
            default:   sel_idx = old_idx;
        endcase
    end

    assign promote = (state == ST_COMMIT) && lat_on;

    voice_age_tracker #(
        .VOICES  (VOICES),
        .V_WIDTH (V_WIDTH)
    ) u_age (
        .OSC_CLK     (OSC_CLK),
        .reset_reg_N (reset_reg_N),
        .promote     (promote),
        .promote_idx (sel_idx),
        .is_oldest   (is_oldest)
    );

    always_ff @(posedge OSC_CLK or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) state_nxt = ST_SCAN;
            end
            ST_SCAN: begin
                if (last_scan) state_nxt = ST_COMMIT;
            end
            ST_COMMIT: begin
                state_nxt = lat_on ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                if (hold_done) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge OSC_CLK or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            scan_idx    <= '0;
            hold_cnt    <= '0;
            aon_pend    <= 1'b0;
            lat_on      <= 1'b0;
            lat_key     <= '0;
            lat_vel     <= '0;
            match_f     <= 1'b0;
            free_f      <= 1'b0;
            old_f       <= 1'b0;
            match_idx   <= '0;
            free_idx    <= '0;
            old_idx     <= '0;
            keys_on     <= '0;
            note_on     <= 1'b0;
            cur_key_adr <= '0;
            cur_key_val <= '0;
            cur_vel_on  <= '0;
            cur_vel_off <= '0;
            for (int i = 0; i < VOICES; i++) begin
                key_mem[i] <= '0;
            end
        end else begin
            if (state != ST_IDLE && all_notes_off) begin
                aon_pend <= 1'b1;
            end
            unique case (state)
                ST_IDLE: begin
                    if (aon_now) begin
                        keys_on  <= '0;
                        aon_pend <= 1'b0;
                    end else if (accept) begin
                        lat_on   <= ev_bus.ev_is_on;
                        lat_key  <= ev_bus.ev_key;
                        lat_vel  <= ev_bus.ev_vel;
                        match_f  <= 1'b0;
                        free_f   <= 1'b0;
                        old_f    <= 1'b0;
                        scan_idx <= '0;
                    end
                end
                ST_SCAN: begin
                    if (is_match && !match_f) begin
                        match_f   <= 1'b1;
                        match_idx <= scan_idx;
                    end
                    if (is_free && !free_f) begin
                        free_f   <= 1'b1;
                        free_idx <= scan_idx;
                    end
                    if (is_old && !old_f) begin
                        old_f   <= 1'b1;
                        old_idx <= scan_idx;
                    end
                    scan_idx <= scan_idx + 1'b1;
                end
                ST_COMMIT: begin
                    hold_cnt <= '0;
                    if (lat_on) begin
                        keys_on[sel_idx] <= 1'b1;
                        key_mem[sel_idx] <= lat_key;
                        cur_key_adr      <= sel_idx;
                        cur_key_val      <= lat_key;
                        cur_vel_on       <= lat_vel;
                        note_on          <= 1'b1;
                    end else if (match_f) begin
                        keys_on[match_idx] <= 1'b0;
                        cur_vel_off        <= lat_vel;
                    end
                end
                ST_HOLD: begin
                    hold_cnt <= hold_cnt + 1'b1;
                    if (hold_done) note_on <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
